gpu_command_queue: RTL

//  Sits directly downstream of the APB command decoder. Captures each command strobe
//  (4-bit opcode + 25-bit parameters) into a FIFO and issues the commands one at a time
//  to the GPU execution engine. It uses a valid/ready issue handshake, then waits for a

---
 rtl/gpu_command_queue.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gpu_command_queue.sv
// Command FIFO between the APB decoder and the GPU engine: issues one command at a time and
// waits for its done pulse. Define GPU_CMDQ_TIMEOUT_EN to add a WAIT_DONE watchdog.
module gpu_command_queue #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     command_i,
    input  logic [3:0]               opcode_i,
    input  logic [24:0]              parameters_i,
    output logic                     exec_valid_o,
    output logic [3:0]               exec_opcode_o,
    output logic [24:0]              exec_params_o,
    input  logic                     exec_ready_i,
    input  logic                     exec_done_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    input  logic                     overflow_clr_i,
    output logic                     timeout_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("gpu_command_queue: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    state_e            state_q, state_d;
    logic [28:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q;
    logic              is_full, is_empty;
    logic              push_req, push, pop, overflow_set;
    logic              wd_expire;

    assign is_full  = (count_q == CntW'(DEPTH));
    assign is_empty = (count_q == '0);

    // NOP strobes never reach the queue; a full queue still accepts when the head leaves.
    assign push_req     = command_i && (opcode_i != 4'h0);
    assign pop          = (state_q == StIssue) && exec_ready_i;
    assign push         = push_req && (!is_full || pop);
    assign overflow_set = push_req && is_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {opcode_i, parameters_i};
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!is_empty) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (exec_ready_i) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (exec_done_i || wd_expire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef GPU_CMDQ_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    logic [ToW-1:0] wd_cnt_q;
    logic           timeout_q;

    // Counter is held at zero outside WAIT_DONE, so every entry starts a fresh window.
    assign wd_expire = (state_q == StWaitDone) && !exec_done_i &&
                       (wd_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != StWaitDone) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + ToW'(1);
            end
            if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Head data is forced to zero while not issuing so the unreset storage never shows.
    assign exec_valid_o  = (state_q == StIssue);
    assign exec_opcode_o = exec_valid_o ? mem_q[rd_ptr_q][28:25] : 4'h0;
    assign exec_params_o = exec_valid_o ? mem_q[rd_ptr_q][24:0] : 25'h0;
    assign fifo_count_o  = count_q;
    assign full_o        = is_full;
    assign empty_o       = is_empty;
    assign overflow_o    = overflow_q;

`ifndef SYNTHESIS
    a_issue_stable: assert property (@(posedge clk) disable iff (rst)
        exec_valid_o && !exec_ready_i |=> exec_valid_o && $stable(exec_opcode_o) &&
                                          $stable(exec_params_o));
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CntW'(DEPTH));
`endif

endmodule
